ram_byte_writer: RTL

- Write-side companion to the 8-bit RAM read path (port b, `q_b`).
- Accepts 32-bit word store requests from the CPU/bus side through a valid/ready handshake and buffers them in a small FIFO.
- Serializes each request into up to four byte writes on the 8-bit RAM write port, honouring per-byte enables, little-endian.
- Sits between the core's store path (`WriteData`/`DataAdr`/`MemWrite`) and the RAM write port.

---
 rtl/ram_byte_writer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ram_byte_writer.sv
// Buffers 32-bit store requests in a FIFO and serializes them into byte writes on an 8-bit RAM port.
// Optional write counter output wr_count is enabled by defining RAM_BYTE_WRITER_COUNT_EN.
module ram_byte_writer #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [3:0]        req_be,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done
`ifdef RAM_BYTE_WRITER_COUNT_EN
    ,
    output logic [15:0]       wr_count
`endif
);

    localparam int unsigned WORD_W  = ADDR_W - 2;
    localparam int unsigned ENTRY_W = WORD_W + 36;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    // FIFO storage and pointers
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    // Working registers of the request being serialized
    state_t             r_state;
    logic [WORD_W-1:0]  r_addr;
    logic [31:0]        r_data;
    logic [3:0]         r_be;
    logic [1:0]         r_idx;

    logic [ADDR_W-1:0]  r_ram_address;
    logic [7:0]         r_ram_data;
    logic               r_ram_wren;
    logic               r_done;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;
    logic [WORD_W-1:0]  w_head_addr;
    logic [31:0]        w_head_data;
    logic [3:0]         w_head_be;
    logic [3:0]         w_avail;
    logic [1:0]         w_sel;
    logic               w_found;
    logic [3:0]         w_rest;
    logic [7:0]         w_byte;
    logic               w_unused_addr_bits;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = req_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && enable && !w_empty;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_addr = w_head[ENTRY_W-1:36];
    assign w_head_data = w_head[35:4];
    assign w_head_be   = w_head[3:0];

    assign w_unused_addr_bits = ^{req_addr[31:ADDR_W], req_addr[1:0]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_addr[ADDR_W-1:2], req_data, req_be};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bytes already written are cleared from r_be, so the lowest remaining bit at or above r_idx is next
    always_comb begin
        w_avail = r_be & (4'b1111 << r_idx);
        w_sel   = 2'd0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_avail[i] && !w_found) begin
                w_sel   = 2'(i);
                w_found = 1'b1;
            end
        end
        w_rest = r_be & ~(4'b0001 << w_sel);
        case (w_sel)
            2'd0:    w_byte = r_data[7:0];
            2'd1:    w_byte = r_data[15:8];
            2'd2:    w_byte = r_data[23:16];
            default: w_byte = r_data[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_data        <= '0;
            r_be          <= '0;
            r_idx         <= '0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wren    <= 1'b0;
            r_done        <= 1'b0;
        end else if (enable) begin
            r_ram_wren <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_addr <= w_head_addr;
                        r_data <= w_head_data;
                        r_be   <= w_head_be;
                        r_idx  <= '0;
                        if (w_head_be == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_ram_wren    <= 1'b1;
                    r_ram_address <= {r_addr, w_sel};
                    r_ram_data    <= w_byte;
                    r_be          <= w_rest;
                    if (w_rest == '0) begin
                        r_done  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= w_sel + 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end else begin
            r_ram_wren <= 1'b0;
            r_done     <= 1'b0;
        end
    end

`ifdef RAM_BYTE_WRITER_COUNT_EN
    logic [15:0] r_wr_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_count <= '0;
        end else if (r_ram_wren) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign wr_count = r_wr_count;
`endif

    assign req_ready   = !w_full;
    assign busy        = !w_empty || (r_state != S_IDLE);
    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;
    assign ram_wren    = r_ram_wren;
    assign done        = r_done;

endmodule
